paddle_control: RTL and testbench

PADDLE_CONTROL -- requirements
Module: paddle_control

---
 rtl/paddle_control.sv | 138 +++++++++++++
 tb/tb_paddle_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_control.sv
// Paddle position controller: encoder detents with acceleration, per-frame
// position update with clamping, and a debounced serve button that recenters.
module paddle_control #(
  parameter int SCREEN_H        = 480,
  parameter int PADDLE_H        = 64,
  parameter int ACCEL_WINDOW    = 2_500_000,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       switch,
  input  logic       frame_tick,
  output logic [9:0] paddle_y,
  output logic       serve,
  output logic [1:0] step_level
);

  localparam int YMAX   = SCREEN_H - PADDLE_H;
  localparam int Y_INIT = YMAX / 2;
  localparam int WIN_W  = $clog2(ACCEL_WINDOW + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(ACCEL_WINDOW);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [11:0] YMAX_S  = 12'(YMAX);
  localparam logic signed [11:0] PEND_LO = -12'sd512;
  localparam logic signed [11:0] PEND_HI = 12'sd511;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  dir_t              dir_q, dir_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [1:0]        level_q, level_d;
  logic signed [10:0] pend_q, pend_d;
  logic [9:0]        y_q, y_d;
  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [DB_W-1:0]   dbc_q, dbc_d;
  logic              serve_q, serve_d;

  logic              up_det, dn_det, det;
  logic signed [11:0] step, pend_base, pend_sum, y_sum;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    up_det  = up & ~down;
    dn_det  = down & ~up;
    det     = up_det | dn_det;

    dir_d   = dir_q;
    win_d   = win_q;
    level_d = level_q;

    if (det) begin
      win_d = '0;
      dir_d = up_det ? DIR_UP : DIR_DOWN;
      if (dir_d == dir_q && win_q < WIN_MAX)
        level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
      else
        level_d = 2'd0;
    end else if (win_q < WIN_MAX) begin
      win_d = win_q + WIN_W'(1);
      if (win_d == WIN_MAX) level_d = 2'd0;
    end

    // A detent in a frame_tick cycle lands in the freshly cleared pending.
    step      = 12'sd1 <<< level_d;
    pend_base = frame_tick ? 12'sd0 : {pend_q[10], pend_q};
    if (up_det)      pend_sum = pend_base - step;
    else if (dn_det) pend_sum = pend_base + step;
    else             pend_sum = pend_base;

    if (pend_sum < PEND_LO)      pend_d = PEND_LO[10:0];
    else if (pend_sum > PEND_HI) pend_d = PEND_HI[10:0];
    else                         pend_d = pend_sum[10:0];

    y_sum = $signed({2'b00, y_q}) + {pend_q[10], pend_q};
    y_d   = y_q;
    if (frame_tick) begin
      if (y_sum < 12'sd0)       y_d = 10'd0;
      else if (y_sum > YMAX_S)  y_d = YMAX_S[9:0];
      else                      y_d = y_sum[9:0];
    end

    db_d  = db_q;
    dbc_d = '0;
    if (sync2_q != db_q) begin
      if (dbc_q == DB_LAST) db_d  = sync2_q;
      else                  dbc_d = dbc_q + DB_W'(1);
    end

    serve_d = db_d & ~db_q;
    if (serve_d) begin
      y_d    = 10'(Y_INIT);
      pend_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= DIR_NONE;
      win_q   <= WIN_MAX;
      level_q <= 2'd0;
      pend_q  <= '0;
      y_q     <= 10'(Y_INIT);
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      dbc_q   <= '0;
      serve_q <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      win_q   <= win_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      sync1_q <= switch;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbc_q   <= dbc_d;
      serve_q <= serve_d;
    end
  end

  assign paddle_y   = y_q;
  assign serve      = serve_q;
  assign step_level = level_q;

endmodule

// File: tb/tb_paddle_control.sv
// Directed bench for paddle_control with a short acceleration window and
// debounce interval; all expected values are hand-computed constants.
module tb_paddle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       switch = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle_y;
  logic       serve;
  logic [1:0] step_level;

  int tests = 0;
  int fails = 0;

  paddle_control #(
    .ACCEL_WINDOW   (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up),
    .down      (down),
    .switch    (switch),
    .frame_tick(frame_tick),
    .paddle_y  (paddle_y),
    .serve     (serve),
    .step_level(step_level)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic det_up(input int n);
    up = 1'b1;
    repeat (n) @(negedge clk);
    up = 1'b0;
  endtask

  task automatic det_dn(input int n);
    down = 1'b1;
    repeat (n) @(negedge clk);
    down = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    up = 1'b0; down = 1'b0; switch = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    up = 1'b0; down = 1'b0; switch = 1'b0; frame_tick = 1'b0;
    rst_n = 1'b0;
    idle(2);
    tests++;
    if (paddle_y !== 10'd208) begin fails++; $display("FAIL reset_y: got %0d want 208", paddle_y); end
    tests++;
    if (serve !== 1'b0) begin fails++; $display("FAIL reset_serve: got %0b want 0", serve); end
    tests++;
    if (step_level !== 2'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", step_level); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_accel();
    do_reset();
    det_up(1); idle(1);
    det_up(1); idle(1);
    det_up(1);
    frame();
    tests++;
    if (paddle_y !== 10'd201) begin fails++; $display("FAIL accel_y: got %0d want 201", paddle_y); end
    tests++;
    if (step_level !== 2'd2) begin fails++; $display("FAIL accel_level: got %0d want 2", step_level); end
    idle(6);
    tests++;
    if (step_level !== 2'd2) begin fails++; $display("FAIL window_edge_minus1: got %0d want 2", step_level); end
    idle(1);
    tests++;
    if (step_level !== 2'd0) begin fails++; $display("FAIL window_expire: got %0d want 0", step_level); end
  endtask

  task automatic test_window_timeout();
    do_reset();
    det_dn(1);
    idle(10);
    tests++;
    if (step_level !== 2'd0) begin fails++; $display("FAIL timeout_level_mid: got %0d want 0", step_level); end
    det_dn(1);
    tests++;
    if (step_level !== 2'd0) begin fails++; $display("FAIL timeout_level_after: got %0d want 0", step_level); end
    frame();
    tests++;
    if (paddle_y !== 10'd210) begin fails++; $display("FAIL timeout_y: got %0d want 210", paddle_y); end
  endtask

  task automatic test_alternate();
    int bad_level;
    bad_level = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      det_up(1);
      if (step_level !== 2'd0) bad_level++;
      idle(1);
      det_dn(1);
      if (step_level !== 2'd0) bad_level++;
      idle(1);
    end
    tests++;
    if (bad_level != 0) begin fails++; $display("FAIL alternate_level: got %0d nonzero samples want 0", bad_level); end
    frame();
    tests++;
    if (paddle_y !== 10'd208) begin fails++; $display("FAIL alternate_y: got %0d want 208", paddle_y); end
  endtask

  task automatic test_clamp();
    do_reset();
    det_dn(60);
    frame();
    tests++;
    if (paddle_y !== 10'd416) begin fails++; $display("FAIL clamp_bottom_fill: got %0d want 416", paddle_y); end
    det_up(1); idle(10); det_up(1);
    frame();
    tests++;
    if (paddle_y !== 10'd414) begin fails++; $display("FAIL clamp_setup_414: got %0d want 414", paddle_y); end
    det_dn(5);
    frame();
    tests++;
    if (paddle_y !== 10'd416) begin fails++; $display("FAIL clamp_bottom: got %0d want 416", paddle_y); end
    det_up(140);
    frame();
    tests++;
    if (paddle_y !== 10'd0) begin fails++; $display("FAIL pending_saturate: got %0d want 0", paddle_y); end
    det_dn(1); idle(10); det_dn(1);
    frame();
    tests++;
    if (paddle_y !== 10'd2) begin fails++; $display("FAIL clamp_setup_2: got %0d want 2", paddle_y); end
    det_up(5);
    frame();
    tests++;
    if (paddle_y !== 10'd0) begin fails++; $display("FAIL clamp_top: got %0d want 0", paddle_y); end
  endtask

  task automatic test_serve();
    int pulses;
    int at_k;
    logic [9:0] y_at;
    pulses = 0; at_k = -1; y_at = '0;
    do_reset();
    det_up(1);
    frame();
    tests++;
    if (paddle_y !== 10'd207) begin fails++; $display("FAIL serve_setup_y: got %0d want 207", paddle_y); end
    det_up(1);
    switch = 1'b1;
    for (int k = 0; k < 2; k++) begin @(negedge clk); if (serve) pulses++; end
    switch = 1'b0;
    for (int k = 0; k < 2; k++) begin @(negedge clk); if (serve) pulses++; end
    switch = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (serve) begin pulses++; at_k = k; y_at = paddle_y; end
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL serve_count: got %0d pulses want 1", pulses); end
    tests++;
    if (at_k != 6) begin fails++; $display("FAIL serve_timing: got cycle %0d want 6", at_k); end
    tests++;
    if (y_at !== 10'd208) begin fails++; $display("FAIL serve_recenter: got %0d want 208", y_at); end
    frame();
    tests++;
    if (paddle_y !== 10'd208) begin fails++; $display("FAIL serve_pending_clear: got %0d want 208", paddle_y); end
    pulses = 0;
    switch = 1'b0;
    for (int k = 0; k < 12; k++) begin @(negedge clk); if (serve) pulses++; end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL release_silent: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_frame_coincide();
    do_reset();
    det_up(1);
    idle(10);
    up = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    up = 1'b0; frame_tick = 1'b0;
    tests++;
    if (paddle_y !== 10'd207) begin fails++; $display("FAIL coincide_first: got %0d want 207", paddle_y); end
    frame();
    tests++;
    if (paddle_y !== 10'd206) begin fails++; $display("FAIL coincide_second: got %0d want 206", paddle_y); end
  endtask

  task automatic test_both_pressed();
    do_reset();
    det_up(1); idle(1);
    det_up(1);
    tests++;
    if (step_level !== 2'd1) begin fails++; $display("FAIL both_setup_level: got %0d want 1", step_level); end
    idle(1);
    up = 1'b1; down = 1'b1;
    @(negedge clk);
    up = 1'b0; down = 1'b0;
    tests++;
    if (step_level !== 2'd1) begin fails++; $display("FAIL both_ignored_level: got %0d want 1", step_level); end
    idle(1);
    det_up(1);
    tests++;
    if (step_level !== 2'd2) begin fails++; $display("FAIL both_continue_level: got %0d want 2", step_level); end
    frame();
    tests++;
    if (paddle_y !== 10'd201) begin fails++; $display("FAIL both_ignored_y: got %0d want 201", paddle_y); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    det_up(1); idle(1); det_up(1);
    switch = 1'b1;
    idle(4);
    rst_n = 1'b0;
    switch = 1'b0;
    #1;
    tests++;
    if (step_level !== 2'd0) begin fails++; $display("FAIL midreset_level: got %0d want 0", step_level); end
    tests++;
    if (paddle_y !== 10'd208) begin fails++; $display("FAIL midreset_y: got %0d want 208", paddle_y); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    frame();
    tests++;
    if (paddle_y !== 10'd208) begin fails++; $display("FAIL midreset_pending: got %0d want 208", paddle_y); end
    det_up(1);
    frame();
    tests++;
    if (paddle_y !== 10'd207) begin fails++; $display("FAIL midreset_first_step: got %0d want 207", paddle_y); end
    tests++;
    if (serve !== 1'b0) begin fails++; $display("FAIL midreset_serve: got %0b want 0", serve); end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_window_timeout();
    test_alternate();
    test_clamp();
    test_serve();
    test_frame_coincide();
    test_both_pressed();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
